// File: rtl/uart_byte_scan_mux.sv
// Byte-history scan driver for a multiplexed 7-segment display fed by UART Rx.
// Optional build macro LEADING_ZERO_BLANK_EN keeps never-written digits dark.
module uart_byte_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  clear,
    output logic                  nib_w,
    output logic                  nib_x,
    output logic                  nib_y,
    output logic                  nib_z,
    output logic [NUM_DIGITS-1:0] anode,
    output logic                  dp,
    output logic [2:0]            digit_idx
);

    localparam int BUF_W   = 4 * NUM_DIGITS;
    localparam int PRESC_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [2:0]         IDX_LAST   = 3'(NUM_DIGITS - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [BUF_W-1:0]      r_buf;
    logic [BUF_W-1:0]      w_bufBase;
    logic [BUF_W-1:0]      w_bufNext;
    logic [PRESC_W-1:0]    r_presc;
    logic [2:0]            r_idx;
    logic                  w_slotWrap;
    logic [0:0]            w_slotState;
    logic [3:0]            w_curNib;
    logic                  w_digitOn;
    logic [NUM_DIGITS-1:0] w_driveAnode;
    logic [NUM_DIGITS-1:0] w_flagAll;
    logic [3:0]            r_nib;
    logic [NUM_DIGITS-1:0] r_anode;
    logic                  r_dp;

    // Clear takes effect before the shift so a simultaneous byte still lands.
    always_comb begin
        w_bufBase = clear ? '0 : r_buf;
        w_bufNext = w_bufBase;
        if (rx_valid) begin
            w_bufNext = (w_bufBase << 8) | BUF_W'(rx_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf <= '0;
        end else begin
            r_buf <= w_bufNext;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] r_flag;
    logic [NUM_DIGITS-1:0] w_flagBase;
    logic [NUM_DIGITS-1:0] w_flagNext;

    // Written flags track the buffer one byte (two digits) at a time.
    always_comb begin
        w_flagBase = clear ? '0 : r_flag;
        w_flagNext = w_flagBase;
        if (rx_valid) begin
            w_flagNext = (w_flagBase << 2) | NUM_DIGITS'(2'b11);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag <= '0;
        end else begin
            r_flag <= w_flagNext;
        end
    end

    assign w_flagAll = r_flag;
`else
    assign w_flagAll = '1;
`endif

    assign w_slotWrap  = (r_presc >= PRESC_LAST);
    assign w_slotState = (r_presc == '0) ? ST_BLANK : ST_DRIVE;

    // Both counters compare with >= so a corrupted value still wraps cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            if (w_slotWrap) begin
                r_presc <= '0;
                if (r_idx >= IDX_LAST) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + 3'd1;
                end
            end else begin
                r_presc <= r_presc + PRESC_W'(1);
            end
        end
    end

    always_comb begin
        w_curNib     = '0;
        w_digitOn    = 1'b0;
        w_driveAnode = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == 3'(k)) begin
                w_curNib  = r_buf[4*k +: 4];
                w_digitOn = w_flagAll[k];
            end
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((r_idx == 3'(k)) && w_digitOn) begin
                w_driveAnode[k] = 1'b0;
            end
        end
    end

    // Nibble is latched only in BLANK so a mid-slot write never tears a digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nib   <= '0;
            r_anode <= '1;
            r_dp    <= 1'b1;
        end else if (w_slotState == ST_BLANK) begin
            r_nib   <= w_curNib;
            r_anode <= '1;
            r_dp    <= 1'b1;
        end else begin
            r_anode <= w_driveAnode;
            r_dp    <= ~(r_idx[0] & w_digitOn);
        end
    end

    assign nib_w     = r_nib[3];
    assign nib_x     = r_nib[2];
    assign nib_y     = r_nib[1];
    assign nib_z     = r_nib[0];
    assign anode     = r_anode;
    assign dp        = r_dp;
    assign digit_idx = r_idx;

endmodule

// File: tb/tb_uart_byte_scan_mux.sv
// Randomized and directed bench for uart_byte_scan_mux against a byte-history
// reference model driven purely by cycle count arithmetic.
module tb_uart_byte_scan_mux;

    localparam int N    = 4;
    localparam int R    = 4;
    localparam int HALF = N / 2;

    logic         clk;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         clear;
    logic         nib_w;
    logic         nib_x;
    logic         nib_y;
    logic         nib_z;
    logic [N-1:0] anode;
    logic         dp;
    logic [2:0]   digit_idx;

    int nCompared;
    int nMismatched;

    // Model state: newest byte first, bytes received since clear, cycles since reset.
    logic [7:0] hist [0:HALF-1];
    int         histCount;
    int         t;
    logic [3:0] mNib;
    logic [3:0] shown [0:N-1];

    uart_byte_scan_mux #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(R)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .clear    (clear),
        .nib_w    (nib_w),
        .nib_x    (nib_x),
        .nib_y    (nib_y),
        .nib_z    (nib_z),
        .anode    (anode),
        .dp       (dp),
        .digit_idx(digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed %h expected %h (t=%0d)", tag, observed, expected, t);
        end
    endtask

    function automatic logic [3:0] nibbleOf(input int k);
        logic [7:0] b;
        b = hist[k / 2];
        return (k % 2 == 1) ? b[7:4] : b[3:0];
    endfunction

    function automatic bit digitWritten(input int k);
`ifdef LEADING_ZERO_BLANK_EN
        return (k / 2) < histCount;
`else
        return 1'b1;
`endif
    endfunction

    task automatic applyStimulus(input bit doRst, input bit doRx, input logic [7:0] data, input bit doClr);
        logic [N-1:0] eAnode;
        logic [3:0]   eNib;
        logic         eDp;
        int           eIdx;
        int           p;
        int           k;
        @(negedge clk);
        rst      = doRst;
        rx_valid = doRx;
        rx_data  = data;
        clear    = doClr;
        if (doRst) begin
            eAnode = '1;
            eNib   = 4'h0;
            eDp    = 1'b1;
            eIdx   = 0;
            for (int i = 0; i < HALF; i++) hist[i] = 8'h00;
            histCount = 0;
            t    = 0;
            mNib = 4'h0;
        end else begin
            p      = t % R;
            k      = (t / R) % N;
            eNib   = (p == 0) ? nibbleOf(k) : mNib;
            mNib   = eNib;
            eAnode = '1;
            eDp    = 1'b1;
            if (p != 0 && digitWritten(k)) begin
                eAnode[k] = 1'b0;
                eDp       = (k % 2 == 1) ? 1'b0 : 1'b1;
            end
            eIdx = ((t + 1) / R) % N;
            if (doClr) begin
                for (int i = 0; i < HALF; i++) hist[i] = 8'h00;
                histCount = 0;
            end
            if (doRx) begin
                for (int i = HALF - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0]   = data;
                histCount = (histCount < HALF) ? histCount + 1 : HALF;
            end
            t++;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        clear    = 1'b0;
        checkOutput("anode", 32'(anode), 32'(eAnode));
        checkOutput("nibble", 32'({nib_w, nib_x, nib_y, nib_z}), 32'(eNib));
        checkOutput("dp", 32'(dp), 32'(eDp));
        checkOutput("digit_idx", 32'(digit_idx), 32'(eIdx));
        for (int j = 0; j < N; j++) begin
            if (anode[j] == 1'b0) shown[j] = {nib_w, nib_x, nib_y, nib_z};
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic resetShown();
        for (int j = 0; j < N; j++) shown[j] = 4'hF;
    endtask

    task automatic checkShown(input string tag, input logic [15:0] expectDigits);
        logic [15:0] obs;
        obs = {shown[3], shown[2], shown[1], shown[0]};
        checkOutput(tag, 32'(obs), 32'(expectDigits));
    endtask

    initial begin
        bit found;
        nCompared   = 0;
        nMismatched = 0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        clear    = 1'b0;
        t        = 0;
        resetShown();

        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

        resetShown();
        idleCycles(2 * N * R + 2);
`ifndef LEADING_ZERO_BLANK_EN
        checkShown("idle_digits", 16'h0000);
`endif

        applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0);
        resetShown();
        idleCycles(24);
        checkShown("rx_A5_3C", 16'hA53C);

        applyStimulus(1'b0, 1'b1, 8'h11, 1'b0);
        idleCycles(3);
        applyStimulus(1'b0, 1'b1, 8'h22, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h33, 1'b0);
        resetShown();
        idleCycles(24);
        checkShown("rx_11_22_33", 16'h2233);

        applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0);
        idleCycles(5);
        applyStimulus(1'b0, 1'b1, 8'h7E, 1'b1);
        resetShown();
        idleCycles(24);
`ifndef LEADING_ZERO_BLANK_EN
        checkShown("clear_plus_rx", 16'h007E);
`endif

        found = 1'b0;
        for (int i = 0; i < 4 * N * R; i++) begin
            if (((t / R) % N) == 2 && (t % R) == 2) begin
                found = 1'b1;
                break;
            end
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        end
        if (!found) checkOutput("reach_digit2_drive", 32'd0, 32'd1);
        applyStimulus(1'b1, 1'b1, 8'h99, 1'b0);
        checkOutput("midscan_rst_anode", 32'(anode), 32'hF);
        checkOutput("midscan_rst_idx", 32'(digit_idx), 32'd0);
        resetShown();
        idleCycles(24);
`ifndef LEADING_ZERO_BLANK_EN
        checkShown("after_midscan_rst", 16'h0000);
`endif

        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom_range(99) == 0), ($urandom_range(4) == 0),
                          8'($urandom), ($urandom_range(19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
